seqmult_rr_sched: RTL

Round-robin scheduler that shares one sequential signed-by-unsigned multiplier (start/ready handshake, A signed M bits, B unsigned N bits, R signed M+N bits) among NREQ requesters. It arbitrates requests, issues the start pulse with the winner's operands, and tracks the multiplier through completion. It then returns the product with a per-requester done pulse. It sits between the client blocks and the multiplier instance, so the clients never drive the multiplier directly.

---
 rtl/seqmult_rr_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seqmult_rr_sched.sv
// Round-robin scheduler that shares one sequential signed-by-unsigned multiplier
// among NREQ requesters and returns each product with a per-requester done pulse.
module seqmult_rr_sched #(
    parameter int NREQ = 4,
    parameter int M    = 18,
    parameter int N    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*M-1:0] req_A,
    input  logic [NREQ*N-1:0] req_B,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [M+N-1:0]    result,
    output logic              busy,
    output logic              mult_start,
    output logic [M-1:0]      mult_A,
    output logic [N-1:0]      mult_B,
    input  logic              mult_ready,
    input  logic [M+N-1:0]    mult_R
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        WAIT_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [M-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [M+N-1:0]    res_q, res_d;

    logic              grant_valid;
    logic [IW-1:0]     grant_idx;
    logic [IW:0]       cand;
    logic [M-1:0]      sel_a;
    logic [N-1:0]      sel_b;

    // Search starts just after the last winner and wraps, so the most recent
    // winner always has the lowest priority on the next decision.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!grant_valid && req[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_a = req_A[i*M +: M];
                sel_b = req_B[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ack_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (mult_ready && grant_valid) begin
                    a_d              = sel_a;
                    b_d              = sel_b;
                    start_d          = 1'b1;
                    ack_d[grant_idx] = 1'b1;
                    last_d           = grant_idx;
                    state_d          = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!mult_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // last_q still names the requester that owns this operation.
                if (mult_ready) begin
                    res_d          = mult_R;
                    done_d[last_q] = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ-1);
            ack_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign result     = res_q;
    assign busy       = busy_q;
    assign mult_start = start_q;
    assign mult_A     = a_q;
    assign mult_B     = b_q;

endmodule
